clk_en_ctrl: RTL and testbench

//  Runtime-programmable clock-enable sequencer for the 8051 core and its peripherals on a 50MHz board clock.

---
 rtl/clk_en_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_clk_en_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_ctrl.sv
// -----------------------------------------------------------------------------
// clk_en_ctrl
//
// Purpose:
//   This block is the clock-enable sequencer for the 8051 core and its
//   peripherals. It divides clk_in by a divisor that can be changed at run
//   time and issues one clk_en pulse in each period. A new divisor is taken
//   over a req/ack handshake and takes effect only at a period boundary, so a
//   period is never cut short. The block also provides run/halt control and
//   debug single-step.
//
// Parameters:
//   DIV_WIDTH  width of the divisor and of the period counter
//   DIV_RESET  divisor loaded at reset
//
// Ports:
//   clk_in     in   system clock; all logic runs on posedge
//   rst        in   synchronous reset, active-high
//   run        in   level: 1 = free-running enables, 0 = halt at next boundary
//   step_req   in   one-cycle pulse: run exactly one period while halted
//   div_req    in   level: request a load of div_val
//   div_val    in   requested divisor; must stay stable while div_req=1
//   div_ack    out  one-cycle pulse in the cycle the new divisor takes effect
//   div_cur    out  divisor in use (after clamping)
//   clk_en     out  one-cycle enable pulse, one per period
//   halted     out  1 while the sequencer is in HALT
//   step_done  out  one-cycle pulse when a single step finishes
//   clk_out    out  divided clock with ~50% duty (only in the optional build)
//   state_dbg  out  current FSM state, for debug and checkers
//
// Optional feature:
//   CLK_EN_CTRL_CLKOUT_EN  when defined, clk_out toggles in every boundary
//                          cycle. When undefined, clk_out is tied to 0.
//
// Handshake (div_req / div_ack):
//   The requester raises div_req with div_val stable. The block captures the
//   clamped value once, on a cycle with no pending value and no ack. div_ack
//   pulses for one cycle when that value becomes div_cur. The requester must
//   drop div_req by the end of the ack cycle. If div_req is still high in the
//   cycle after the ack, the block treats it as a new request.
//
// Every output is registered. The clk_en, div_ack and step_done pulses are
// worked out from next-state values, so each pulse sits in the boundary cycle
// itself and not one cycle later.
// -----------------------------------------------------------------------------
module clk_en_ctrl #(
  parameter int          DIV_WIDTH = 8,
  parameter int unsigned DIV_RESET = 5
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 step_req,
  input  logic                 div_req,
  input  logic [DIV_WIDTH-1:0] div_val,
  output logic                 div_ack,
  output logic [DIV_WIDTH-1:0] div_cur,
  output logic                 clk_en,
  output logic                 halted,
  output logic                 step_done,
  output logic                 clk_out,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DIV_RESET);

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cntr_q, cntr_d;
  logic [DIV_WIDTH-1:0] div_cur_q, div_cur_d;
  logic [DIV_WIDTH-1:0] pend_q, pend_d;
  logic                 pend_vld_q, pend_vld_d;
  logic                 clk_en_q, clk_en_d;
  logic                 div_ack_q, div_ack_d;
  logic                 step_done_q, step_done_d;
  logic                 halted_q, halted_d;

  logic bnd;     // the current cycle is the last cycle of a period
  logic bnd_d;   // the next cycle will be the last cycle of a period
  logic latch;   // capture div_val into the pending register
  logic apply;   // pending divisor becomes div_cur at the end of this cycle

  always_comb begin
    state_d     = state_q;
    cntr_d      = cntr_q;
    div_cur_d   = div_cur_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;

    bnd   = (state_q != ST_HALT) && (cntr_q == (div_cur_q - ONE));
    // The ack cycle is excluded as well, so a requester that holds div_req
    // into the ack cycle does not re-trigger.
    latch = div_req && !pend_vld_q && !div_ack_q;
    // In HALT there is no period in progress, so a pending value is applied
    // at once. Otherwise it waits for the boundary.
    apply = pend_vld_q && (bnd || (state_q == ST_HALT));

    unique case (state_q)
      ST_HALT: begin
        if (run) begin
          state_d = ST_RUN;
        end else if (step_req) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (bnd && !run) begin
          state_d = ST_HALT;
        end
      end
      ST_STEP: begin
        if (bnd) begin
          state_d = run ? ST_RUN : ST_HALT;
        end
      end
      default: state_d = ST_HALT;
    endcase

    if (latch) begin
      pend_d     = (div_val <= ONE) ? ONE : div_val;
      pend_vld_d = 1'b1;
    end else if (apply) begin
      pend_vld_d = 1'b0;
    end

    if (apply) begin
      div_cur_d = pend_q;
    end

    // The counter is 0 whenever a new divisor is applied, so a smaller
    // divisor can never leave cntr at or above div_cur.
    if ((state_d == ST_HALT) || bnd || (state_q == ST_HALT)) begin
      cntr_d = '0;
    end else begin
      cntr_d = cntr_q + ONE;
    end

    bnd_d       = (state_d != ST_HALT) && (cntr_d == (div_cur_d - ONE));
    clk_en_d    = bnd_d;
    step_done_d = bnd_d && (state_d == ST_STEP);
    div_ack_d   = pend_vld_d && (bnd_d || (state_d == ST_HALT));
    halted_d    = (state_d == ST_HALT);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= ST_HALT;
      cntr_q      <= '0;
      div_cur_q   <= DIV_RST;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      clk_en_q    <= 1'b0;
      div_ack_q   <= 1'b0;
      step_done_q <= 1'b0;
      halted_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      cntr_q      <= cntr_d;
      div_cur_q   <= div_cur_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      clk_en_q    <= clk_en_d;
      div_ack_q   <= div_ack_d;
      step_done_q <= step_done_d;
      halted_q    <= halted_d;
    end
  end

`ifdef CLK_EN_CTRL_CLKOUT_EN
  logic clk_out_q, clk_out_d;

  // The toggle lines up with clk_en, and the level is held while halted.
  always_comb begin
    clk_out_d = clk_out_q ^ bnd_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      clk_out_q <= 1'b0;
    end else begin
      clk_out_q <= clk_out_d;
    end
  end

  assign clk_out = clk_out_q;
`else
  assign clk_out = 1'b0;
`endif

  assign div_ack   = div_ack_q;
  assign div_cur   = div_cur_q;
  assign clk_en    = clk_en_q;
  assign halted    = halted_q;
  assign step_done = step_done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_clk_en_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_en_ctrl
//
// Bench for clk_en_ctrl.
//
// Each directed scenario computes by hand the cycle numbers of the pulse
// events it expects and pushes them into exp_q. Each entry holds the cycle,
// the pulse flags, halted and div_cur. A monitor watches every cycle on the
// falling edge:
//   - When any pulse appears, it pops one entry and compares it.
//   - An expected entry whose cycle has gone by is reported as missed.
//   - A pulse that arrives with nothing queued is reported as unexpected.
// Level checks (halted, div_cur, clk_out) are made directly by the stimulus.
//
// Cycle numbering: cyc counts rising edges. "Cycle n" is the interval after
// rising edge n. Inputs change 1 time unit after a rising edge, and outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_clk_en_ctrl;

  localparam int W  = 8;
  localparam int RW = 44;  // {cycle[31:0], clk_en, div_ack, step_done, halted, div_cur[7:0]}

  // clock / reset
  logic clk_in = 1'b0;
  always #10 clk_in = ~clk_in;

  logic         rst;
  logic         run;
  logic         step_req;
  logic         div_req;
  logic [W-1:0] div_val;
  logic         div_ack;
  logic [W-1:0] div_cur;
  logic         clk_en;
  logic         halted;
  logic         step_done;
  logic         clk_out;
  logic [1:0]   state_dbg;

  clk_en_ctrl #(.DIV_WIDTH(W), .DIV_RESET(5)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .run       (run),
    .step_req  (step_req),
    .div_req   (div_req),
    .div_val   (div_val),
    .div_ack   (div_ack),
    .div_cur   (div_cur),
    .clk_en    (clk_en),
    .halted    (halted),
    .step_done (step_done),
    .clk_out   (clk_out),
    .state_dbg (state_dbg)
  );

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] mon_act;
  logic [RW-1:0] mon_exp;
  logic [RW-1:0] mon_head;

  function automatic logic [RW-1:0] mk(int c, bit ce, bit ack, bit sd, bit h, logic [W-1:0] dc);
    return {32'(c), ce, ack, sd, h, dc};
  endfunction

  // driver tasks
  task automatic push_exp(int c, bit ce, bit ack, bit sd, bit h, logic [W-1:0] dc);
    exp_q.push_back(mk(c, ce, ack, sd, h, dc));
  endtask

  task automatic wait_to(int c);
    while (cyc < c) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic at_neg(int c);
    wait_to(c);
    @(negedge clk_in);
  endtask

  task automatic check(string name, int act, int exp_v);
    n_chk++;
    if (act == exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk_in) begin
    if (mon_en) begin
      while (exp_q.size() > 0) begin
        mon_head = exp_q[0];
        if (int'(mon_head[43:12]) < cyc) begin
          n_chk++;
          $display("FAIL missed_event: expected %h not seen by cycle %0d", mon_head, cyc);
          void'(exp_q.pop_front());
        end else begin
          break;
        end
      end
      if (clk_en || div_ack || step_done) begin
        mon_act = mk(cyc, clk_en, div_ack, step_done, halted, div_cur);
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_event: got %h expected none", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_act === mon_exp) begin
            n_pass++;
          end else begin
            $display("FAIL event: got %h expected %h", mon_act, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int c, c2, c3;

  initial begin
    rst = 1'b1; run = 1'b0; step_req = 1'b0; div_req = 1'b0; div_val = '0;
    repeat (3) @(posedge clk_in);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk_in);
    check("reset_halted", halted, 1);
    check("reset_div_cur", div_cur, 5);
    check("reset_pulses", {29'd0, clk_en, div_ack, step_done}, 0);
    check("reset_clk_out", clk_out, 0);
    @(posedge clk_in); #1;

    // Free run at divisor 5; run dropped mid-period halts after the boundary.
    c = cyc;
    run = 1'b1;
    push_exp(c + 5,  1, 0, 0, 0, 5);
    push_exp(c + 10, 1, 0, 0, 0, 5);
    push_exp(c + 15, 1, 0, 0, 0, 5);
    wait_to(c + 12); run = 1'b0;
    at_neg(c + 16);
    check("halt_after_bnd", halted, 1);
    wait_to(c + 25);

    // div_val=0 in HALT: ack the cycle after latch, clamp to 1, enable every cycle.
    c = cyc;
    div_req = 1'b1; div_val = 8'd0;
    push_exp(c + 1, 0, 1, 0, 1, 5);
    wait_to(c + 1); div_req = 1'b0;
    at_neg(c + 2);
    check("clamp_div_cur", div_cur, 1);
    wait_to(c + 3);
    c2 = cyc;
    run = 1'b1;
    for (int k = 1; k <= 4; k++) push_exp(c2 + k, 1, 0, 0, 0, 1);
    wait_to(c2 + 4); run = 1'b0;
    at_neg(c2 + 6);
    check("halt_div1", halted, 1);
    wait_to(c2 + 8);

    // Divisor 4, single step, then step_req ignored while running.
    c = cyc;
    div_req = 1'b1; div_val = 8'd4;
    push_exp(c + 1, 0, 1, 0, 1, 1);
    wait_to(c + 1); div_req = 1'b0;
    wait_to(c + 3);
    c2 = cyc;
    step_req = 1'b1;
    push_exp(c2 + 4, 1, 0, 1, 0, 4);
    wait_to(c2 + 1); step_req = 1'b0;
    at_neg(c2 + 5);
    check("halt_after_step", halted, 1);
    wait_to(c2 + 6);
    c3 = cyc;
    run = 1'b1;
    push_exp(c3 + 4,  1, 0, 0, 0, 4);
    push_exp(c3 + 8,  1, 0, 0, 0, 4);
    push_exp(c3 + 12, 1, 0, 0, 0, 4);
    wait_to(c3 + 5); step_req = 1'b1;
    wait_to(c3 + 6); step_req = 1'b0;
    wait_to(c3 + 9); run = 1'b0;
    at_neg(c3 + 13);
    check("halt_after_run4", halted, 1);
    wait_to(c3 + 16);

    // Boundary with run=0 and a pending divisor: apply, ack and halt together.
    c = cyc;
    run = 1'b1;
    push_exp(c + 4, 1, 1, 0, 0, 4);
    wait_to(c + 2); div_req = 1'b1; div_val = 8'd2; run = 1'b0;
    wait_to(c + 4); div_req = 1'b0;
    at_neg(c + 5);
    check("simul_halted", halted, 1);
    check("simul_div_cur", div_cur, 2);
    wait_to(c + 8);

    // Latch in a boundary cycle applies at the following boundary.
    c = cyc;
    run = 1'b1;
    push_exp(c + 2,  1, 0, 0, 0, 2);
    push_exp(c + 4,  1, 0, 0, 0, 2);
    push_exp(c + 6,  1, 1, 0, 0, 2);
    push_exp(c + 9,  1, 0, 0, 0, 3);
    push_exp(c + 12, 1, 0, 0, 0, 3);
    wait_to(c + 4); div_req = 1'b1; div_val = 8'd3;
    wait_to(c + 6); div_req = 1'b0;
    wait_to(c + 10); run = 1'b0;
    at_neg(c + 13);
    check("latch_at_bnd_halted", halted, 1);
    check("latch_at_bnd_div_cur", div_cur, 3);
    wait_to(c + 15);

    // Divisor 5 -> 3 while running; no short period, and div_val changes ignored while pending.
    c = cyc;
    div_req = 1'b1; div_val = 8'd5;
    push_exp(c + 1, 0, 1, 0, 1, 3);
    wait_to(c + 1); div_req = 1'b0;
    wait_to(c + 3);
    c2 = cyc;
    run = 1'b1;
    push_exp(c2 + 5,  1, 0, 0, 0, 5);
    push_exp(c2 + 10, 1, 0, 0, 0, 5);
    push_exp(c2 + 15, 1, 1, 0, 0, 5);
    push_exp(c2 + 18, 1, 0, 0, 0, 3);
    push_exp(c2 + 21, 1, 0, 0, 0, 3);
    wait_to(c2 + 12); div_req = 1'b1; div_val = 8'd3;
    wait_to(c2 + 14); div_val = 8'd9;
    wait_to(c2 + 15); div_req = 1'b0;
    wait_to(c2 + 19); run = 1'b0;
    at_neg(c2 + 22);
    check("switch_halted", halted, 1);
    check("switch_div_cur", div_cur, 3);
    wait_to(c2 + 24);

    // Reset while a divisor is pending mid-period: discarded, no ack.
    c = cyc;
    run = 1'b1;
    push_exp(c + 3, 1, 0, 0, 0, 3);
    wait_to(c + 4); div_req = 1'b1; div_val = 8'd7;
    wait_to(c + 5); rst = 1'b1;
    wait_to(c + 6); rst = 1'b0; div_req = 1'b0; run = 1'b0;
    @(negedge clk_in);
    check("rst2_halted", halted, 1);
    check("rst2_div_cur", div_cur, 5);
    check("rst2_clk_out", clk_out, 0);
    at_neg(c + 9);
    check("rst2_no_apply", div_cur, 5);
    wait_to(c + 10);
    c2 = cyc;
    run = 1'b1;
    push_exp(c2 + 5,  1, 0, 0, 0, 5);
    push_exp(c2 + 10, 1, 0, 0, 0, 5);
    wait_to(c2 + 6); run = 1'b0;
    at_neg(c2 + 11);
    check("post_rst_halted", halted, 1);
    wait_to(c2 + 14);

    @(negedge clk_in);
    while (exp_q.size() > 0) begin
      n_chk++;
      $display("FAIL leftover_event: expected %h never seen", exp_q.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
